pa_core_flowctrl: RTL

Pipeline flow controller that sequences the core's program-counter generator. It arbitrates redirect requests from soft reset, trap entry/return and execute-stage branches. It defers redirects while the pipeline is stalled and drives the PC generator's reset, jump and hold controls. It also generates the flush window that kills wrong-path instructions in the fetch/decode stages.

---
 rtl/pa_core_flowctrl_pkg.sv | 26 ++
 rtl/pa_core_redirect_arb.sv | 41 ++++
 rtl/pa_core_flowctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pa_core_flowctrl_pkg.sv
// Shared encodings for the pipeline flow controller.
package pa_core_flowctrl_pkg;

  localparam int DATA_BUS_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PK_NONE   = 2'd0,
    PK_TRAP   = 2'd1,
    PK_BRANCH = 2'd2
  } pend_kind_t;

  // Winner of the redirect priority select for the current cycle.
  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_RESET  = 2'd1,
    SEL_TRAP   = 2'd2,
    SEL_BRANCH = 2'd3
  } sel_t;

endpackage

// File: rtl/pa_core_redirect_arb.sv
// Priority select among soft reset, trap (pending or live) and branch (pending or live).
module pa_core_redirect_arb
  import pa_core_flowctrl_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_WIDTH
) (
  input  logic              soft_reset,
  input  logic              trap_req,
  input  logic [DATA_W-1:0] trap_addr,
  input  logic              branch_req,
  input  logic              branch_en,
  input  logic [DATA_W-1:0] branch_addr,
  input  logic [1:0]        pend_kind,
  input  logic [DATA_W-1:0] pend_addr,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] sel_addr
);

  // A latched entry wins over a live request of the same kind, so a held
  // trap is acked once and the first latched branch is kept.
  always_comb begin
    sel      = SEL_NONE;
    sel_addr = '0;
    if (soft_reset) begin
      sel = SEL_RESET;
    end else if (pend_kind == PK_TRAP) begin
      sel      = SEL_TRAP;
      sel_addr = pend_addr;
    end else if (trap_req) begin
      sel      = SEL_TRAP;
      sel_addr = trap_addr;
    end else if (pend_kind == PK_BRANCH) begin
      sel      = SEL_BRANCH;
      sel_addr = pend_addr;
    end else if (branch_req && branch_en) begin
      sel      = SEL_BRANCH;
      sel_addr = branch_addr;
    end
  end

endmodule

// File: rtl/pa_core_flowctrl.sv
// Flow controller: arbitrates redirects, defers them across stalls and
// drives PC generator controls plus the IF/ID flush window.
module pa_core_flowctrl
  import pa_core_flowctrl_pkg::*;
#(
  parameter int DATA_W       = DATA_BUS_WIDTH,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              soft_reset_req_i,
  input  logic              trap_req_i,
  input  logic [DATA_W-1:0] trap_addr_i,
  input  logic              branch_req_i,
  input  logic [DATA_W-1:0] branch_addr_i,
  input  logic              mem_stall_i,
  input  logic              muldiv_busy_i,
  output logic              reset_flag_o,
  output logic              jump_flag_o,
  output logic [DATA_W-1:0] jump_addr_o,
  output logic              hold_flag_o,
  output logic              flush_o,
  output logic              trap_ack_o
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  state_t            state_q, state_d;
  pend_kind_t        pend_kind_q, pend_kind_d;
  logic [DATA_W-1:0] pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall;
  logic              issue;
  logic [1:0]        sel;
  logic [DATA_W-1:0] sel_addr;

  assign stall       = mem_stall_i | muldiv_busy_i;
  assign hold_flag_o = stall;

  // Branches seen during the flush window come from wrong-path instructions.
  pa_core_redirect_arb #(
    .DATA_W(DATA_W)
  ) u_arb (
    .soft_reset (soft_reset_req_i),
    .trap_req   (trap_req_i),
    .trap_addr  (trap_addr_i),
    .branch_req (branch_req_i),
    .branch_en  (state_q != ST_FLUSH),
    .branch_addr(branch_addr_i),
    .pend_kind  (pend_kind_q),
    .pend_addr  (pend_addr_q),
    .sel        (sel),
    .sel_addr   (sel_addr)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_RUN;
      pend_kind_q <= PK_NONE;
      pend_addr_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_kind_q <= pend_kind_d;
      pend_addr_q <= pend_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_kind_d  = pend_kind_q;
    pend_addr_d  = pend_addr_q;
    cnt_d        = cnt_q;
    reset_flag_o = 1'b0;
    jump_flag_o  = 1'b0;
    jump_addr_o  = '0;
    trap_ack_o   = 1'b0;
    issue        = 1'b0;

    // Outputs are gated by reset so nothing is issued while it is asserted.
    if (rst_n_i) begin
      case (sel)
        SEL_RESET: begin
          reset_flag_o = 1'b1;
          issue        = 1'b1;
        end
        SEL_TRAP, SEL_BRANCH: begin
          if (!stall) begin
            jump_flag_o = 1'b1;
            jump_addr_o = sel_addr;
            trap_ack_o  = (sel == SEL_TRAP);
            issue       = 1'b1;
          end else begin
            pend_kind_d = (sel == SEL_TRAP) ? PK_TRAP : PK_BRANCH;
            pend_addr_d = sel_addr;
          end
        end
        default: ;
      endcase
    end

    // cnt_q counts the FLUSH-state cycles left; the issue cycle flushes too.
    if (issue) begin
      pend_kind_d = PK_NONE;
      cnt_d       = CNT_W'(FLUSH_CYCLES - 1);
      state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else if (state_q == ST_FLUSH) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q <= CNT_W'(1)) begin
        state_d = (pend_kind_d != PK_NONE) ? ST_PEND : ST_RUN;
      end
    end else begin
      state_d = (pend_kind_d != PK_NONE) ? ST_PEND : ST_RUN;
    end

    flush_o = issue | (state_q == ST_FLUSH);
  end

endmodule
